// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths and the point type for the ECC result path.
package ecc_pkg;
    localparam int DATA_WIDTH      = 192;
    localparam int WORD_WIDTH      = 32;
    localparam int WORDS_PER_COORD = DATA_WIDTH / WORD_WIDTH;
    localparam int WORDS_PER_PT    = 2 * WORDS_PER_COORD;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] x;
        logic [DATA_WIDTH-1:0] y;
    } pt_t;
endpackage

// File: rtl/ecc_pt_fifo.sv
// ecc_pt_fifo: two-entry point buffer; callers only push when there is room
// (or when a pop frees the head in the same cycle).
module ecc_pt_fifo
    import ecc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  pt_t        wr_pt,
    output logic       full,
    output logic       empty,
    output logic [1:0] count,
    output pt_t        head
);
    pt_t  mem [2];
    logic wr_ptr;
    logic rd_ptr;
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_pt;
    end
    assign full  = count == 2'd2;
    assign empty = count == 2'd0;
    assign head  = mem[rd_ptr];
endmodule

// File: rtl/ecc_result_serializer.sv
// ecc_result_serializer: streams buffered (x, y) results as MSW-first words,
// x before y, with a sticky flag for points dropped while the buffer is full.
module ecc_result_serializer #(
    parameter int DATA_WIDTH = 192,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Rx,
    input  logic [DATA_WIDTH-1:0] Ry,
    input  logic                  pt_valid,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  ovf,
    output logic                  busy
);
    import ecc_pkg::pt_t;
    localparam int WPP = 2 * DATA_WIDTH / WORD_WIDTH;
    localparam int IW  = $clog2(WPP);
    localparam logic [IW-1:0] LAST_IDX = IW'(WPP - 1);
    pt_t                    in_pt;
    pt_t                    head;
    logic                   full;
    logic                   empty;
    logic [1:0]             count;
    logic [IW-1:0]          idx;
    logic [2*DATA_WIDTH-1:0] flat;
    logic                   xfer;
    logic                   pop;
    logic                   push;
    assign in_pt = {Rx, Ry};
    ecc_pt_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wr_pt (in_pt),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );
    assign flat    = {head.x, head.y};
    assign m_valid = !empty;
    assign busy    = count != 2'd0;
    assign m_last  = m_valid && idx == LAST_IDX;
    assign m_data  = flat[2*DATA_WIDTH-1 - int'(idx)*WORD_WIDTH -: WORD_WIDTH];
    assign xfer    = m_valid && m_ready;
    assign pop     = xfer && m_last;
    // A full buffer still accepts a point when the head's last word leaves now.
    assign push    = pt_valid && (!full || pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            ovf <= 1'b0;
        end else begin
            if (xfer) idx <= m_last ? '0 : idx + 1'b1;
            if (pt_valid && full && !pop) ovf <= 1'b1;
        end
    end
endmodule
